// File: rtl/param_accum_core.sv
// param_accum_core
//
// Parametrised accumulator/carry/index-register processor core. Instructions
// are fetched one at a time over a request/valid handshake, then executed in
// a single cycle, so an instruction takes two cycles when memory answers
// immediately. The core holds an accumulator, a carry/borrow flag, NREGS
// index registers, a program counter and a registered output port.
//
// Instruction format: op = instr_data[7:4], operand n = instr_data[3:0].
// The index register selected by an instruction is n % NREGS.
//
// Optional feature macro: ACCUM_CORE_DAA_EN
//   defined   -> opcode F is a decimal adjust of the accumulator (DAA)
//   undefined -> opcode F is a NOP
//
// Parameters:
//   DATA_W  accumulator, index register and I/O width (>= 4)
//   NREGS   number of index registers (2..16)
//   PC_W    program counter / instruction address width
//
// Ports:
//   clk_1         in   1       clock, rising edge
//   reset         in   1       asynchronous active-low reset
//   instr_addr    out  PC_W    fetch address (the PC)
//   instr_req     out  1       fetch request, high throughout FETCH
//   instr_valid   in   1       instr_data valid; fetch completes on req & valid
//   instr_data    in   8       instruction byte
//   io_in         in   DATA_W  input port, sampled by RDR
//   io_out        out  DATA_W  output register, written by WRR
//   io_out_valid  out  1       one-cycle pulse when io_out is written
//   acc           out  DATA_W  accumulator
//   carry_out     out  1       carry/borrow flag
//   halted        out  1       high in the HALT state

module param_accum_core #(
    parameter int DATA_W = 4,
    parameter int NREGS  = 16,
    parameter int PC_W   = 12
) (
    input  logic              clk_1,
    input  logic              reset,
    output logic [PC_W-1:0]   instr_addr,
    output logic              instr_req,
    input  logic              instr_valid,
    input  logic [7:0]        instr_data,
    input  logic [DATA_W-1:0] io_in,
    output logic [DATA_W-1:0] io_out,
    output logic              io_out_valid,
    output logic [DATA_W-1:0] acc,
    output logic              carry_out,
    output logic              halted
);

    typedef enum logic [1:0] {
        ST_FETCH,
        ST_EXEC,
        ST_HALT
    } state_t;

    localparam logic [3:0] OP_NOP = 4'h0;
    localparam logic [3:0] OP_LDM = 4'h1;
    localparam logic [3:0] OP_LD  = 4'h2;
    localparam logic [3:0] OP_XCH = 4'h3;
    localparam logic [3:0] OP_ADD = 4'h4;
    localparam logic [3:0] OP_SUB = 4'h5;
    localparam logic [3:0] OP_INC = 4'h6;
    localparam logic [3:0] OP_CLB = 4'h7;
    localparam logic [3:0] OP_IAC = 4'h8;
    localparam logic [3:0] OP_RAL = 4'h9;
    localparam logic [3:0] OP_WRR = 4'hA;
    localparam logic [3:0] OP_RDR = 4'hB;
    localparam logic [3:0] OP_JZ  = 4'hC;
    localparam logic [3:0] OP_JMP = 4'hD;
    localparam logic [3:0] OP_HLT = 4'hE;
    localparam logic [3:0] OP_F   = 4'hF;

    state_t            state;
    state_t            state_nxt;

    logic [PC_W-1:0]   pc;
    logic [7:0]        ir;
    logic [DATA_W-1:0] acc_q;
    logic              carry_q;
    logic [DATA_W-1:0] regs [NREGS];

    logic [3:0]        op;
    logic [3:0]        n;
    logic [3:0]        reg_idx;
    logic [DATA_W-1:0] r_val;
    logic [PC_W-1:0]   pc_inc;
    logic [PC_W-1:0]   pc_jump;
    logic [DATA_W:0]   add_sum;
    logic [DATA_W:0]   sub_diff;
    logic [DATA_W:0]   inc_sum;
`ifdef ACCUM_CORE_DAA_EN
    logic [DATA_W:0]   daa_sum;
`endif

    logic [PC_W-1:0]   pc_nxt;
    logic [DATA_W-1:0] acc_nxt;
    logic              carry_nxt;
    logic              reg_we;
    logic [DATA_W-1:0] reg_wd;
    logic              io_we;

    // State register.
    always_ff @(posedge clk_1 or negedge reset) begin
        if (!reset) begin
            state <= ST_FETCH;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic: FETCH waits for the handshake, EXEC always takes one
    // cycle, HALT is left only through reset.
    always_comb begin
        state_nxt = state;
        case (state)
            ST_FETCH: if (instr_valid) state_nxt = ST_EXEC;
            ST_EXEC:  state_nxt = (op == OP_HLT) ? ST_HALT : ST_FETCH;
            ST_HALT:  state_nxt = ST_HALT;
            default:  state_nxt = ST_FETCH;
        endcase
    end

    assign op      = ir[7:4];
    assign n       = ir[3:0];
    assign reg_idx = 4'({28'd0, n} % NREGS);
    assign r_val   = regs[reg_idx];

    // Relative jumps are taken from the address of the following instruction
    // with a sign-extended 4-bit offset; both sums wrap modulo 2^PC_W.
    assign pc_inc  = pc + PC_W'(1);
    assign pc_jump = pc_inc + PC_W'($signed(n));

    // The extra top bit of each sum is the carry out (or the borrow for SUB,
    // since a negative difference sets it in two's complement).
    assign add_sum  = {1'b0, acc_q} + {1'b0, r_val} + (DATA_W+1)'(carry_q);
    assign sub_diff = {1'b0, acc_q} - {1'b0, r_val} - (DATA_W+1)'(carry_q);
    assign inc_sum  = {1'b0, acc_q} + (DATA_W+1)'(1);
`ifdef ACCUM_CORE_DAA_EN
    assign daa_sum  = {1'b0, acc_q} + (DATA_W+1)'(6);
`endif

    // Instruction decode: work out the architectural updates for the
    // instruction held in ir. They are only committed during EXEC.
    always_comb begin
        pc_nxt    = pc_inc;
        acc_nxt   = acc_q;
        carry_nxt = carry_q;
        reg_we    = 1'b0;
        reg_wd    = r_val;
        io_we     = 1'b0;
        case (op)
            OP_NOP: ;
            OP_LDM: acc_nxt = DATA_W'(n);
            OP_LD:  acc_nxt = r_val;
            OP_XCH: begin
                acc_nxt = r_val;
                reg_we  = 1'b1;
                reg_wd  = acc_q;
            end
            OP_ADD: {carry_nxt, acc_nxt} = add_sum;
            OP_SUB: {carry_nxt, acc_nxt} = sub_diff;
            OP_INC: begin
                reg_we = 1'b1;
                reg_wd = r_val + DATA_W'(1);
            end
            OP_CLB: begin
                acc_nxt   = '0;
                carry_nxt = 1'b0;
            end
            OP_IAC: {carry_nxt, acc_nxt} = inc_sum;
            OP_RAL: {carry_nxt, acc_nxt} = {acc_q, carry_q};
            OP_WRR: io_we = 1'b1;
            OP_RDR: acc_nxt = io_in;
            OP_JZ:  if (acc_q == '0) pc_nxt = pc_jump;
            OP_JMP: pc_nxt = pc_jump;
            OP_HLT: ;
            OP_F: begin
`ifdef ACCUM_CORE_DAA_EN
                // Carry is only ever set here, never cleared.
                if ((acc_q[3:0] > 4'd9) || carry_q) begin
                    acc_nxt = daa_sum[DATA_W-1:0];
                    if (daa_sum[DATA_W]) carry_nxt = 1'b1;
                end
`endif
            end
            default: ;
        endcase
    end

    // Datapath registers. The instruction byte is captured on the fetch
    // handshake; everything else changes only in EXEC. io_out_valid is
    // cleared every cycle so a WRR produces exactly one pulse.
    always_ff @(posedge clk_1 or negedge reset) begin
        if (!reset) begin
            pc           <= '0;
            ir           <= '0;
            acc_q        <= '0;
            carry_q      <= 1'b0;
            io_out       <= '0;
            io_out_valid <= 1'b0;
            for (int i = 0; i < NREGS; i++) begin
                regs[i] <= '0;
            end
        end else begin
            io_out_valid <= 1'b0;
            if ((state == ST_FETCH) && instr_valid) begin
                ir <= instr_data;
            end
            if (state == ST_EXEC) begin
                pc      <= pc_nxt;
                acc_q   <= acc_nxt;
                carry_q <= carry_nxt;
                if (reg_we) begin
                    regs[reg_idx] <= reg_wd;
                end
                if (io_we) begin
                    io_out       <= acc_q;
                    io_out_valid <= 1'b1;
                end
            end
        end
    end

    // The state register resets to FETCH, so the request is gated with reset
    // to keep it low while reset is held, without waiting for a clock edge.
    assign instr_req  = (state == ST_FETCH) && reset;
    assign instr_addr = pc;
    assign acc        = acc_q;
    assign carry_out  = carry_q;
    assign halted     = (state == ST_HALT);

endmodule

// File: tb/tb_param_accum_core.sv
// tb_param_accum_core
//
// Directed bench for param_accum_core (DATA_W=4, NREGS=16, PC_W=12). Small
// programs are placed in a 64-entry instruction memory addressed by the low
// six bits of instr_addr; expected results are hand-computed constants.
// Honours ACCUM_CORE_DAA_EN for the opcode F program.

module tb_param_accum_core;

    logic        clk_1;
    logic        reset;
    logic [11:0] instr_addr;
    logic        instr_req;
    logic        instr_valid;
    logic [7:0]  instr_data;
    logic [3:0]  io_in;
    logic [3:0]  io_out;
    logic        io_out_valid;
    logic [3:0]  acc;
    logic        carry_out;
    logic        halted;

    logic [7:0]  prog [64];
    int          n_vectors;
    int          n_miscompares;
    int          pulse_cnt;
    logic [11:0] fa;

    param_accum_core #(.DATA_W(4), .NREGS(16), .PC_W(12)) dut (
        .clk_1        (clk_1),
        .reset        (reset),
        .instr_addr   (instr_addr),
        .instr_req    (instr_req),
        .instr_valid  (instr_valid),
        .instr_data   (instr_data),
        .io_in        (io_in),
        .io_out       (io_out),
        .io_out_valid (io_out_valid),
        .acc          (acc),
        .carry_out    (carry_out),
        .halted       (halted)
    );

    assign instr_data = prog[instr_addr[5:0]];

    initial clk_1 = 1'b0;
    always #5 clk_1 = ~clk_1;

    // Count output-port write pulses, sampled away from the active edge.
    always @(negedge clk_1) begin
        if (io_out_valid) pulse_cnt++;
    end

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vectors++;
        if (got !== exp) begin
            n_miscompares++;
            $display("[TB] FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Fill memory with HLT so a stray fetch stops the core.
    task automatic clear_prog();
        for (int i = 0; i < 64; i++) prog[i] = 8'hE0;
    endtask

    // Pulse reset and release it; returns just after the release with the
    // core sitting in FETCH at address 0.
    task automatic applyStimulus();
        @(negedge clk_1);
        reset = 1'b0;
        repeat (2) @(negedge clk_1);
        reset = 1'b1;
        #1;
    endtask

    task automatic run_to_halt(input string tag, input int max_cycles);
        for (int i = 0; i < max_cycles; i++) begin
            @(negedge clk_1);
            if (halted) break;
        end
        checkOutput(tag, 32'(halted), 32'd1);
    endtask

    // Advance from the current fetch to the next one and return its address.
    task automatic next_fetch(output logic [11:0] addr);
        bit seen_exec;
        bit found;
        seen_exec = 1'b0;
        found     = 1'b0;
        addr      = '1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk_1);
            #1;
            if (!instr_req) begin
                seen_exec = 1'b1;
            end else if (seen_exec) begin
                addr  = instr_addr;
                found = 1'b1;
                break;
            end
        end
        checkOutput("fetch_found", 32'(found), 32'd1);
    endtask

    initial begin
        n_vectors     = 0;
        n_miscompares = 0;
        pulse_cnt     = 0;
        reset         = 1'b0;
        instr_valid   = 1'b1;
        io_in         = 4'h0;
        clear_prog();

        // Reset values while reset is held.
        #12;
        checkOutput("rst_acc",   32'(acc),          32'h0);
        checkOutput("rst_carry", 32'(carry_out),    32'h0);
        checkOutput("rst_req",   32'(instr_req),    32'h0);
        checkOutput("rst_addr",  32'(instr_addr),   32'h0);
        checkOutput("rst_io",    32'(io_out),       32'h0);
        checkOutput("rst_iov",   32'(io_out_valid), 32'h0);
        checkOutput("rst_halt",  32'(halted),       32'h0);

        // LDM 9, XCH 1, LDM 8, ADD 1: 8 + 9 = 0x11.
        clear_prog();
        prog[0] = 8'h19; prog[1] = 8'h31; prog[2] = 8'h18; prog[3] = 8'h41;
        applyStimulus();
        checkOutput("first_req",  32'(instr_req),  32'd1);
        checkOutput("first_addr", 32'(instr_addr), 32'd0);
        run_to_halt("add_halt", 40);
        checkOutput("add_acc",   32'(acc),       32'h1);
        checkOutput("add_carry", 32'(carry_out), 32'h1);

        // Same program then LD 1 reads R1 back.
        prog[4] = 8'h21;
        applyStimulus();
        run_to_halt("r1_halt", 40);
        checkOutput("r1_acc",   32'(acc),       32'h9);
        checkOutput("r1_carry", 32'(carry_out), 32'h1);

        // CLB, LDM 3, XCH 2, LDM 1, SUB 2: 1 - 3 = -2 with borrow.
        clear_prog();
        prog[0] = 8'h70; prog[1] = 8'h13; prog[2] = 8'h32; prog[3] = 8'h11;
        prog[4] = 8'h52;
        applyStimulus();
        run_to_halt("sub_halt", 40);
        checkOutput("sub_acc",   32'(acc),       32'hE);
        checkOutput("sub_carry", 32'(carry_out), 32'h1);

        // LDM F, IAC, RAL, INC 3 x2, LD 3, XCH 5, RDR, RAL, ADD 5 -> 7, carry 0.
        clear_prog();
        prog[0] = 8'h1F; prog[1] = 8'h80; prog[2] = 8'h90; prog[3] = 8'h63;
        prog[4] = 8'h63; prog[5] = 8'h23; prog[6] = 8'h35; prog[7] = 8'hB0;
        prog[8] = 8'h90; prog[9] = 8'h45;
        io_in = 4'hA;
        applyStimulus();
        run_to_halt("mix_halt", 60);
        checkOutput("mix_acc",   32'(acc),       32'h7);
        checkOutput("mix_carry", 32'(carry_out), 32'h0);
        io_in = 4'h0;

        // Fetch stall at address 3: request and address held, state frozen.
        clear_prog();
        prog[0] = 8'h15; prog[1] = 8'h00; prog[2] = 8'h00; prog[3] = 8'h17;
        applyStimulus();
        next_fetch(fa); next_fetch(fa); next_fetch(fa);
        checkOutput("stall_addr0", 32'(fa), 32'd3);
        instr_valid = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk_1);
            #1;
            checkOutput("stall_req",  32'(instr_req),  32'd1);
            checkOutput("stall_addr", 32'(instr_addr), 32'd3);
            checkOutput("stall_acc",  32'(acc),        32'h5);
        end
        instr_valid = 1'b1;
        run_to_halt("stall_halt", 20);
        checkOutput("stall_acc_end", 32'(acc), 32'h7);

        // CLB, JZ +2 -> 4; JMP -1 at 5 loops on itself.
        clear_prog();
        prog[0] = 8'h70; prog[1] = 8'hC2; prog[2] = 8'h1F; prog[3] = 8'h1F;
        prog[4] = 8'h11; prog[5] = 8'hDF;
        applyStimulus();
        next_fetch(fa);
        checkOutput("jz_src",   32'(fa), 32'd1);
        next_fetch(fa);
        checkOutput("jz_tgt",   32'(fa), 32'd4);
        next_fetch(fa);
        checkOutput("jmp_src",  32'(fa), 32'd5);
        next_fetch(fa);
        checkOutput("jmp_self", 32'(fa), 32'd5);
        next_fetch(fa);
        checkOutput("jmp_self2", 32'(fa), 32'd5);
        checkOutput("jmp_acc",  32'(acc), 32'h1);

        // JZ -3 at 0 wraps to 0xFFE; PC then wraps 0xFFF -> 0.
        clear_prog();
        prog[0] = 8'hCD; prog[1] = 8'hE0; prog[62] = 8'h16; prog[63] = 8'h00;
        applyStimulus();
        next_fetch(fa);
        checkOutput("wrap_tgt",  32'(fa), 32'hFFE);
        next_fetch(fa);
        checkOutput("wrap_top",  32'(fa), 32'hFFF);
        next_fetch(fa);
        checkOutput("wrap_zero", 32'(fa), 32'h000);
        next_fetch(fa);
        checkOutput("wrap_fall", 32'(fa), 32'h001);
        run_to_halt("wrap_halt", 10);
        checkOutput("wrap_acc",  32'(acc), 32'h6);

        // LDM 5, WRR, HLT: one output pulse, then parked in HALT.
        clear_prog();
        prog[0] = 8'h15; prog[1] = 8'hA0; prog[2] = 8'hE0;
        applyStimulus();
        pulse_cnt = 0;
        run_to_halt("wrr_halt", 20);
        repeat (4) @(negedge clk_1);
        checkOutput("wrr_io",     32'(io_out),    32'h5);
        checkOutput("wrr_pulses", 32'(pulse_cnt), 32'd1);
        checkOutput("wrr_req",    32'(instr_req), 32'd0);
        checkOutput("wrr_halted", 32'(halted),    32'd1);

        // Same program, stalled in the fetch of address 2, then reset is
        // dropped between clock edges.
        applyStimulus();
        next_fetch(fa); next_fetch(fa);
        checkOutput("ar_addr", 32'(fa), 32'd2);
        instr_valid = 1'b0;
        @(negedge clk_1);
        #2;
        checkOutput("ar_pre_io", 32'(io_out), 32'h5);
        reset = 1'b0;
        #1;
        checkOutput("ar_acc",   32'(acc),          32'h0);
        checkOutput("ar_io",    32'(io_out),       32'h0);
        checkOutput("ar_req",   32'(instr_req),    32'h0);
        checkOutput("ar_addr0", 32'(instr_addr),   32'h0);
        checkOutput("ar_iov",   32'(io_out_valid), 32'h0);
        checkOutput("ar_halt",  32'(halted),       32'h0);
        instr_valid = 1'b1;

        // LDM B, opcode F.
        clear_prog();
        prog[0] = 8'h1B; prog[1] = 8'hF0;
        applyStimulus();
        run_to_halt("opf_halt", 20);
`ifdef ACCUM_CORE_DAA_EN
        checkOutput("daa_acc",   32'(acc),       32'h1);
        checkOutput("daa_carry", 32'(carry_out), 32'h1);
`else
        checkOutput("opf_acc",   32'(acc),       32'hB);
        checkOutput("opf_carry", 32'(carry_out), 32'h0);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vectors, n_miscompares);
        $finish;
    end

endmodule
